fir_result_sink: RTL and testbench
==================================

Name: fir_result_sink

Overview:
- Receive end of the FIR filter's output stream. Consumes the filter's 19-bit `y` / `valid_out` stream, which has no backpressure.
- Requantizes each sample to OUT_W bits with round-half-up and unsigned saturation.
- Buffers results in a first-word-fall-through FIFO that drives a valid/ready interface to downstream logic.
- Detects and counts any overflow of that FIFO.

Parameters:
- IN_W, 19, width of the incoming filter result (unsigned).
- OUT_W, 8, width of the requantized output sample.
- SHIFT, 4, right-shift applied before saturation; legal range 1..IN_W-1.
- DEPTH, 4, FIFO depth in entries; power of two, at least 2.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  1  `y_in` carries a new sample this cycle (driven by the filter's `valid_out`).
- y_in  input  IN_W  filter result, unsigned.
- data_out  output  OUT_W  head-of-FIFO sample.
- valid_out  output  1  `data_out` is valid.
- ready_in  input  1  downstream accepts `data_out` this cycle.
- count  output  clog2(DEPTH)+1  current FIFO occupancy.
- sat  output  1  saturation flag of the head entry, stored alongside the data.
- overflow  output  1  one-cycle pulse when an incoming sample is dropped.
- drop_count  output  8  saturating count of dropped samples.

Behaviour:
- Reset (asynchronous, any time, including mid-stream):
  - FIFO empties; read and write pointers go to 0.
  - `valid_out`=0, `data_out`=0, `sat`=0, `count`=0, `overflow`=0, `drop_count`=0.
  - Data in flight is discarded.
- Requantization (combinational on `y_in`):
  - r = (y_in + 2^(SHIFT-1)) >> SHIFT, computed at IN_W+1 bits so the add cannot wrap.
  - If r > 2^OUT_W-1: q = 2^OUT_W-1 and s = 1.
  - Otherwise: q = r[OUT_W-1:0] and s = 0.
- Push:
  - A push is valid_in=1 at a rising edge.
  - {s,q} is written at that edge.
  - Latency is 1 cycle: with an empty FIFO, `valid_out`=1 and `data_out`=q in the cycle after `valid_in`.
- Pop:
  - A pop is valid_out=1 and ready_in=1 at a rising edge.
  - The head advances and the next entry appears on the following cycle.
  - When `valid_out`=0, `ready_in` is ignored.
- Simultaneous push and pop:
  - Both take effect and `count` is unchanged.
  - When full, the pop frees the slot and the push is accepted: no drop, no overflow.
  - When `count`=1, the new entry appears on `data_out` the next cycle with no bubble.
- Full with push and no pop:
  - The sample is dropped.
  - `overflow` is 1 for exactly the cycle after the drop edge.
  - `drop_count` increments and holds at 255 (no wrap).
  - FIFO contents are unchanged.
- Holding: `data_out` and `sat` hold stable while valid_out=1 and ready_in=0.
- Pointers: wrap modulo DEPTH; `count` runs 0..DEPTH.
- State machine (derived from `count`):
  - EMPTY (`count`=0), PARTIAL, FULL (`count`=DEPTH).
  - Transitions occur only via push/pop as above.
  - `valid_out` = (state != EMPTY), registered.

Optional Feature:
- Macro: FIR_SINK_PEAK_EN.
- When defined:
  - Adds output port `peak` [OUT_W-1:0] and input port `peak_clr` [1].
  - `peak` holds the maximum q accepted into the FIFO since reset or since the last `peak_clr`. Dropped samples are not counted.
  - `peak_clr` at an edge sets `peak` to the q being accepted at that same edge, or to 0 if none is accepted.
  - `peak` resets to 0.
- When undefined: neither port nor register exists; all other behaviour is identical.

Test Plan (OUT_W=8, SHIFT=4, DEPTH=4):
- Reset, then valid_in for 1 cycle with y_in=56, ready_in=1 -> next cycle valid_out=1, data_out=4, sat=0; following cycle valid_out=0, count=0.
- y_in=23, then y_in=24, ready_in=1 -> data_out=1, then data_out=2; round-half-up boundary confirmed.
- y_in=0x7FFFF, then y_in=4087 -> data_out=255, sat=1; then data_out=255, sat=0 (4087+8=4095, >>4 = 255 exactly).
- ready_in=0, six pushes with y_in=16,32,...,96 -> count=4; overflow pulses twice; drop_count=2; pops yield 1,2,3,4.
- FIFO full, then a push and a pop on the same edge -> count stays 4, overflow=0, the new sample is the last one popped.
- Reset asserted with count=3, asynchronously mid-cycle -> valid_out=0 immediately, count=0, drop_count=0; after release the first push appears 1 cycle later.

Source files
------------

// File: rtl/fir_result_sink.sv
// Receive end of the FIR output stream: round-half-up requantize, saturate, buffer in a FWFT FIFO.
// Optional peak tracker enabled by defining FIR_SINK_PEAK_EN.
module fir_result_sink #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 8,
  parameter int SHIFT = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic [IN_W-1:0]          y_in,
  output logic [OUT_W-1:0]         data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sat,
  output logic                     overflow,
`ifdef FIR_SINK_PEAK_EN
  output logic [OUT_W-1:0]         peak,
  input  logic                     peak_clr,
`endif
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [IN_W:0]  ONE_W    = {{IN_W{1'b0}}, 1'b1};
  localparam logic [IN_W:0]  RND      = ONE_W << (SHIFT - 1);
  localparam logic [IN_W:0]  QMAX     = {{(IN_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_count, w_count_nxt;
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr, w_rd_inc;
  logic [OUT_W:0]     r_mem [DEPTH];
  logic [OUT_W:0]     r_head, w_head_nxt;
  logic               r_overflow;
  logic [7:0]         r_drop_cnt;

  logic [IN_W:0]      w_sum, w_shr;
  logic               w_s;
  logic [OUT_W-1:0]   w_q;
  logic [OUT_W:0]     w_entry;
  logic               w_pop, w_push, w_drop, w_full;

  // Extra MSB keeps the rounding add from wrapping at full-scale input.
  assign w_sum   = {1'b0, y_in} + RND;
  assign w_shr   = w_sum >> SHIFT;
  assign w_s     = (w_shr > QMAX);
  assign w_q     = w_s ? {OUT_W{1'b1}} : w_shr[OUT_W-1:0];
  assign w_entry = {w_s, w_q};

  assign w_full   = (r_state == ST_FULL);
  assign w_pop    = (r_state != ST_EMPTY) && ready_in;
  assign w_push   = valid_in && (!w_full || w_pop);
  assign w_drop   = valid_in && w_full && !w_pop;
  assign w_rd_inc = r_rd_ptr + AW'(1);

  always_comb begin
    w_count_nxt = r_count;
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
    if (w_count_nxt == {CW{1'b0}}) begin
      w_state_nxt = ST_EMPTY;
    end else if (w_count_nxt == FULL_CNT) begin
      w_state_nxt = ST_FULL;
    end else begin
      w_state_nxt = ST_PARTIAL;
    end
    // The head register is refilled directly from the input when the FIFO would otherwise run dry.
    if (w_push && ((r_count == {CW{1'b0}}) || (w_pop && (r_count == CW'(1))))) begin
      w_head_nxt = w_entry;
    end else if (w_pop && (r_count > CW'(1))) begin
      w_head_nxt = r_mem[w_rd_inc];
    end else begin
      w_head_nxt = r_head;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_count    <= {CW{1'b0}};
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_head     <= {(OUT_W + 1){1'b0}};
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_head     <= w_head_nxt;
      r_overflow <= w_drop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_inc;
      end
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

`ifdef FIR_SINK_PEAK_EN
  logic [OUT_W-1:0] r_peak;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_peak <= {OUT_W{1'b0}};
    end else if (peak_clr) begin
      r_peak <= w_push ? w_q : {OUT_W{1'b0}};
    end else if (w_push && (w_q > r_peak)) begin
      r_peak <= w_q;
    end
  end

  assign peak = r_peak;
`endif

  assign valid_out  = (r_state != ST_EMPTY);
  assign data_out   = r_head[OUT_W-1:0];
  assign sat        = r_head[OUT_W];
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_fir_result_sink.sv
// Scoreboard bench for fir_result_sink (OUT_W=8, SHIFT=4, DEPTH=4, default build).
module tb_fir_result_sink;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [18:0] y_in = 19'd0;
  logic        ready_in = 1'b0;
  logic [7:0]  data_out;
  logic        valid_out;
  logic [2:0]  count;
  logic        sat;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] sb [$];
  logic       exp_ovf   = 1'b0;
  int         exp_drops = 0;

  fir_result_sink #(.IN_W(19), .OUT_W(8), .SHIFT(4), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .y_in(y_in),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
    .count(count), .sat(sat), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  function automatic logic [8:0] model(input logic [18:0] y);
    int r;
    r = (int'(y) + 8) / 16;
    if (r > 255) return {1'b1, 8'hFF};
    return {1'b0, 8'(r)};
  endfunction

  // Drives one cycle and updates the FIFO model; outputs are sampled 1ns after the edge.
  task automatic drive(input logic v, input logic [18:0] y, input logic rdy);
    logic pop, full;
    valid_in = v; y_in = y; ready_in = rdy;
    pop  = (sb.size() != 0) && rdy;
    full = (sb.size() == 4);
    exp_ovf = v && full && !pop;
    if (pop) void'(sb.pop_front());
    if (v && !exp_ovf) sb.push_back(model(y));
    if (exp_ovf && exp_drops != 255) exp_drops++;
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({valid_out, data_out, sat, count, overflow, drop_count} !== 21'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %0h expected 0", {valid_out, data_out, sat, count, overflow, drop_count});
    end
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_latency;
    drive(1'b1, 19'd56, 1'b1);
    n_checks++;
    if ({valid_out, sat, data_out} !== {1'b1, 9'd4}) begin
      n_fail++; $display("FAIL latency_head: got v=%0b s=%0b d=%0d expected v=1 s=0 d=4", valid_out, sat, data_out);
    end
    drive(1'b0, 19'd0, 1'b1);
    n_checks++;
    if (valid_out !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL latency_drain: got v=%0b cnt=%0d expected v=0 cnt=0", valid_out, count);
    end
  endtask

  task automatic test_rounding;
    drive(1'b1, 19'd23, 1'b1);
    n_checks++;
    if (data_out !== sb[0][7:0] || data_out !== 8'd1) begin
      n_fail++; $display("FAIL round_23: got %0d expected 1", data_out);
    end
    drive(1'b1, 19'd24, 1'b1);
    n_checks++;
    if (valid_out !== 1'b1 || data_out !== 8'd2 || count !== 3'd1) begin
      n_fail++; $display("FAIL round_24: got v=%0b d=%0d cnt=%0d expected v=1 d=2 cnt=1", valid_out, data_out, count);
    end
    drive(1'b0, 19'd0, 1'b1);
  endtask

  task automatic test_saturation;
    drive(1'b1, 19'h7FFFF, 1'b0);
    n_checks++;
    if ({sat, data_out} !== sb[0] || {sat, data_out} !== 9'h1FF) begin
      n_fail++; $display("FAIL sat_max: got s=%0b d=%0d expected s=1 d=255", sat, data_out);
    end
    drive(1'b1, 19'd4087, 1'b1);
    n_checks++;
    if ({sat, data_out} !== sb[0] || {sat, data_out} !== 9'h0FF) begin
      n_fail++; $display("FAIL sat_edge: got s=%0b d=%0d expected s=0 d=255", sat, data_out);
    end
    drive(1'b0, 19'd0, 1'b1);
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 19'(16 * i), 1'b0);
      n_checks++;
      if (overflow !== exp_ovf || count !== 3'(sb.size()) || drop_count !== 8'(exp_drops)) begin
        n_fail++; $display("FAIL ovf_push%0d: got ovf=%0b cnt=%0d drops=%0d expected ovf=%0b cnt=%0d drops=%0d",
                           i, overflow, count, drop_count, exp_ovf, sb.size(), exp_drops);
      end
    end
    drive(1'b0, 19'd0, 1'b0);
    n_checks++;
    if (overflow !== 1'b0 || drop_count !== 8'd2) begin
      n_fail++; $display("FAIL ovf_pulse_end: got ovf=%0b drops=%0d expected ovf=0 drops=2", overflow, drop_count);
    end
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (valid_out !== 1'b1 || {sat, data_out} !== sb[0] || data_out !== 8'(i)) begin
        n_fail++; $display("FAIL ovf_pop%0d: got v=%0b d=%0d expected v=1 d=%0d", i, valid_out, data_out, i);
      end
      drive(1'b0, 19'd0, 1'b1);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 4; i++) drive(1'b1, 19'(16 * (i + 1)), 1'b0);
    drive(1'b1, 19'd160, 1'b1);
    n_checks++;
    if (count !== 3'd4 || overflow !== 1'b0 || drop_count !== 8'd2) begin
      n_fail++; $display("FAIL b2b_full: got cnt=%0d ovf=%0b drops=%0d expected cnt=4 ovf=0 drops=2", count, overflow, drop_count);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (valid_out !== 1'b1 || {sat, data_out} !== sb[0]) begin
        n_fail++; $display("FAIL b2b_pop%0d: got v=%0b d=%0d expected v=1 d=%0d", i, valid_out, data_out, sb[0][7:0]);
      end
      if (i == 3) begin
        n_checks++;
        if (data_out !== 8'd10) begin
          n_fail++; $display("FAIL b2b_last: got %0d expected 10", data_out);
        end
      end
      drive(1'b0, 19'd0, 1'b1);
    end
  endtask

  task automatic test_drop_saturate;
    for (int i = 0; i < 4; i++) drive(1'b1, 19'd32, 1'b0);
    for (int i = 0; i < 260; i++) drive(1'b1, 19'd48, 1'b0);
    n_checks++;
    if (drop_count !== 8'd255 || exp_drops != 255) begin
      n_fail++; $display("FAIL drop_sat: got %0d expected 255", drop_count);
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 19'd0, 1'b1);
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 3; i++) drive(1'b1, 19'd80, 1'b0);
    n_checks++;
    if (count !== 3'd3) begin
      n_fail++; $display("FAIL areset_pre: got cnt=%0d expected 3", count);
    end
    valid_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    sb.delete(); exp_drops = 0;
    n_checks++;
    if (valid_out !== 1'b0 || count !== 3'd0 || drop_count !== 8'd0) begin
      n_fail++; $display("FAIL areset_now: got v=%0b cnt=%0d drops=%0d expected 0 0 0", valid_out, count, drop_count);
    end
    @(negedge clock); reset = 1'b0;
    drive(1'b1, 19'd48, 1'b0);
    n_checks++;
    if (valid_out !== 1'b1 || data_out !== 8'd3 || count !== 3'd1) begin
      n_fail++; $display("FAIL areset_after: got v=%0b d=%0d cnt=%0d expected 1 3 1", valid_out, data_out, count);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_saturation();
    test_overflow();
    test_back_to_back();
    test_drop_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
